// File: rtl/param_cpu_counter.sv
// param_cpu_counter: loadable up/down modulo counter with step, terminal count and wrap pulse.
// Define PARAM_CPU_COUNTER_SAT_EN to saturate at 0/MAX_VAL instead of wrapping.
module param_cpu_counter #(
  parameter int WIDTH = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 1,
  parameter longint unsigned STEP = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_en,
  input  logic [WIDTH-1:0] din,
  input  logic             count_en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             wrap
);
`ifdef PARAM_CPU_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] MOD = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH:0] STP = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] TOP = MAX[WIDTH-1:0];
  logic [WIDTH:0] ext, sum, up_w, dn, dn_w;
  logic over, under, wrap_nxt;
  logic [WIDTH-1:0] cnt_up, cnt_dn, nxt;
  // One extra bit keeps dout+STEP and dout+MOD from overflowing.
  assign ext  = {1'b0, dout};
  assign sum  = ext + STP;
  assign up_w = sum - MOD;
  assign dn   = ext - STP;
  assign dn_w = ext + MOD - STP;
  assign over  = sum > MAX;
  assign under = ext < STP;
  assign cnt_up = over ? (SAT ? TOP : up_w[WIDTH-1:0]) : sum[WIDTH-1:0];
  assign cnt_dn = under ? (SAT ? '0 : dn_w[WIDTH-1:0]) : dn[WIDTH-1:0];
  assign tc = up_dn ? (dout == TOP) : (dout == '0);
  always_comb begin
    nxt = write_en ? (({1'b0, din} > MAX) ? TOP : din)
        : count_en ? (up_dn ? cnt_up : cnt_dn)
        : dout;
    wrap_nxt = !SAT && !write_en && count_en && (up_dn ? over : under);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      dout <= '0;
      wrap <= 1'b0;
    end else begin
      dout <= nxt;
      wrap <= wrap_nxt;
    end
  end
endmodule

// File: tb/tb_param_cpu_counter.sv
// tb_param_cpu_counter: scoreboard bench for a default counter and a MAX_VAL=9/STEP=3 counter.
module tb_param_cpu_counter;
`ifdef PARAM_CPU_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n [2];
  logic we [2];
  logic ce [2];
  logic ud [2];
  logic [7:0] din [2];
  logic [7:0] dout [2];
  logic tc [2];
  logic wrap [2];
  param_cpu_counter dut0 (
    .clock(clk), .reset(rst_n[0]), .write_en(we[0]), .din(din[0]), .count_en(ce[0]),
    .up_dn(ud[0]), .dout(dout[0]), .tc(tc[0]), .wrap(wrap[0])
  );
  param_cpu_counter #(.MAX_VAL(9), .STEP(3)) dut1 (
    .clock(clk), .reset(rst_n[1]), .write_en(we[1]), .din(din[1]), .count_en(ce[1]),
    .up_dn(ud[1]), .dout(dout[1]), .tc(tc[1]), .wrap(wrap[1])
  );
  typedef struct {
    int unsigned idx;
    int unsigned d;
    bit w;
    bit t;
  } exp_t;
  exp_t sb [$];
  int unsigned mx [2] = '{255, 9};
  int unsigned st [2] = '{1, 3};
  int unsigned mq [2] = '{0, 0};
  int vectors = 0;
  int errs = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int i, input bit r, input bit w, input bit c, input bit u,
                      input int unsigned d);
    exp_t e;
    int unsigned q, nd;
    bit nw;
    q = mq[i];
    nw = 1'b0;
    for (int j = 0; j < 2; j++) begin
      rst_n[j] = 1'b1;
      we[j] = 1'b0;
      ce[j] = 1'b0;
    end
    rst_n[i] = r;
    we[i] = w;
    ce[i] = c;
    ud[i] = u;
    din[i] = d[7:0];
    if (!r) nd = 0;
    else if (w) nd = (d > mx[i]) ? mx[i] : d;
    else if (c && u) begin
      if (q + st[i] > mx[i]) begin
        nd = SAT ? mx[i] : q + st[i] - mx[i] - 1;
        nw = !SAT;
      end else nd = q + st[i];
    end else if (c) begin
      if (q < st[i]) begin
        nd = SAT ? 0 : q + mx[i] + 1 - st[i];
        nw = !SAT;
      end else nd = q - st[i];
    end else nd = q;
    mq[i] = nd;
    e.idx = i;
    e.d = nd;
    e.w = nw;
    e.t = u ? (nd == mx[i]) : (nd == 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) check("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      check($sformatf("dout%0d", e.idx), dout[e.idx], e.d);
      check($sformatf("wrap%0d", e.idx), wrap[e.idx], e.w);
      check($sformatf("tc%0d", e.idx), tc[e.idx], e.t);
    end
  endtask
  initial begin
    for (int j = 0; j < 2; j++) begin
      rst_n[j] = 1'b0;
      we[j] = 1'b0;
      ce[j] = 1'b0;
      ud[j] = 1'b1;
      din[j] = 8'h00;
    end
    repeat (2) step(0, 0, 0, 0, 1, 0);
    repeat (2) step(1, 0, 0, 0, 1, 0);
    repeat (257) step(0, 1, 0, 1, 1, 0);
    step(0, 1, 1, 1, 1, 'hF0);
    repeat (2) step(0, 1, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1, 'h55);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 1, 'hFE);
    repeat (4) step(0, 1, 0, 1, 1, 0);
    step(0, 1, 1, 0, 0, 1);
    repeat (2) step(0, 1, 0, 1, 0, 0);
    repeat (7) step(1, 1, 0, 1, 1, 0);
    repeat (4) step(1, 1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 1, 15);
    repeat (5) step(1, 1, 0, 0, 1, 0);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 1), $urandom_range(0, 30) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 255));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
